// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_issue_ctrl
// Description : Execute-stage issue/writeback controller for an iterative
//               divider, with divide-by-zero bypass and timeout guard.
// Revision    : 1.0
// ============================================================================
module div_issue_ctrl #(
    parameter int TIMEOUT   = 40,
    parameter int RDY_GUARD = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic [4:0]  in_rd,
    output logic        div_start,
    output logic [31:0] div_A,
    output logic [31:0] div_B,
    input  logic [31:0] div_result,
    input  logic        div_exception,
    input  logic        div_rdy,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] c_guard = 6'(RDY_GUARD);
    localparam logic [5:0] c_last  = 6'(TIMEOUT - 1);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_div_start;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_exc;

    logic w_b_zero;
    assign w_b_zero = (in_B == 32'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_div_start <= 1'b0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_rd        <= 5'd0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_wb_exc    <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            r_wb_valid  <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid) begin
                            if (w_b_zero) begin
                                // Never launched: the divider would only report the same fault.
                                r_state    <= S_DONE;
                                r_wb_valid <= 1'b1;
                                r_wb_rd    <= in_rd;
                                r_wb_data  <= 32'd0;
                                r_wb_exc   <= 1'b1;
                            end else begin
                                r_a         <= in_A;
                                r_b         <= in_B;
                                r_rd        <= in_rd;
                                r_div_start <= 1'b1;
                                r_state     <= S_START;
                            end
                        end
                    end
                    S_START: begin
                        r_cnt   <= 6'd0;
                        r_state <= S_BUSY;
                    end
                    S_BUSY: begin
                        r_cnt <= r_cnt + 6'd1;
                        // Early ready is stale from the previous operation; ready beats timeout.
                        if ((r_cnt >= c_guard) && div_rdy) begin
                            r_state    <= S_DONE;
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= div_exception ? 32'd0 : div_result;
                            r_wb_exc   <= div_exception;
                        end else if (r_cnt == c_last) begin
                            r_state    <= S_DONE;
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= 32'd0;
                            r_wb_exc   <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign stall        = ((r_state == S_IDLE) && in_valid) || (r_state == S_START) ||
                          (r_state == S_BUSY);
    assign div_start    = r_div_start;
    assign div_A        = r_a;
    assign div_B        = r_b;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_exception = r_wb_exc;

endmodule
`default_nettype wire
